// File: rtl/instruction_loader.sv
// Assembles little-endian bytes from a serial receiver into instruction words and
// writes them to instruction memory until the end-of-program marker or the memory fills.
module instruction_loader #(
  parameter int              NB        = 32,
  parameter int              TAM       = 256,
  parameter logic [NB-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start_load,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_done,
  output logic          o_instruction_write,
  output logic [NB-1:0] o_instruction,
  output logic [NB-1:0] o_address_memory_ins,
  output logic          o_busy,
  output logic          o_load_done,
  output logic          o_overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_SETUP,
    S_STROBE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [NB-1:0] LAST_ADDR = NB'(TAM - 1);
  localparam logic [NB-1:0] ADDR_ONE  = NB'(1);

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [NB-1:0] asm_q, asm_d;
  logic [NB-1:0] instr_q, instr_d;
  logic [NB-1:0] addr_q, addr_d;
  logic          pend_q, pend_d;
  logic [NB-1:0] pend_word_q, pend_word_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic [NB-1:0] asm_merged;
  logic          word_done;

  // Assembly register with the current byte dropped into its slot.
  always_comb begin
    asm_merged = asm_q;
    asm_merged[{cnt_q, 3'b000} +: 8] = i_rx_data;
    word_done = i_rx_done && (cnt_q == 2'd3);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    done_d      = done_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start_load) begin
          state_d = S_RECV;
          cnt_d   = 2'd0;
          addr_d  = '0;
          pend_d  = 1'b0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end

      S_RECV: begin
        if (i_rx_done) begin
          asm_d = asm_merged;
          cnt_d = cnt_q + 2'd1;
          if (word_done) begin
            instr_d = asm_merged;
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        state_d = S_STROBE;
        // Bytes keep flowing while the current word is being written; a word that
        // completes here is parked so the next one can follow without a RECV detour.
        if (i_rx_done) begin
          asm_d = asm_merged;
          cnt_d = cnt_q + 2'd1;
          if (word_done) begin
            pend_d      = 1'b1;
            pend_word_d = asm_merged;
          end
        end
      end

      S_STROBE: begin
        if (i_rx_done) begin
          asm_d = asm_merged;
          cnt_d = cnt_q + 2'd1;
        end
        pend_d = 1'b0;
        if (instr_q == HALT_WORD) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_ERROR;
          ovf_d   = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_ONE;
          if (pend_q) begin
            instr_d = pend_word_q;
            state_d = S_SETUP;
          end else if (word_done) begin
            instr_d = asm_merged;
            state_d = S_SETUP;
          end else begin
            state_d = S_RECV;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      asm_q       <= '0;
      instr_q     <= '0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_instruction_write  = (state_q == S_STROBE);
  assign o_instruction        = instr_q;
  assign o_address_memory_ins = addr_q;
  assign o_busy               = (state_q == S_RECV) || (state_q == S_SETUP) || (state_q == S_STROBE);
  assign o_load_done          = done_q;
  assign o_overflow           = ovf_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: byte-stream reference model producing the expected
// memory writes, a per-cycle write monitor, and directed plus randomized loads.
module tb_instruction_loader;

  localparam int          NB   = 32;
  localparam int          TAM  = 256;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk;
  logic          rst;
  logic          start_load;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          wr;
  logic [NB-1:0] instr;
  logic [NB-1:0] addr;
  logic          busy;
  logic          load_done;
  logic          overflow;

  instruction_loader #(.NB(NB), .TAM(TAM), .HALT_WORD(HALT)) dut (
    .i_clk                (clk),
    .i_reset              (rst),
    .i_start_load         (start_load),
    .i_rx_data            (rx_data),
    .i_rx_done            (rx_done),
    .o_instruction_write  (wr),
    .o_instruction        (instr),
    .o_address_memory_ins (addr),
    .o_busy               (busy),
    .o_load_done          (load_done),
    .o_overflow           (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / counters ----------------
  logic [63:0] exp_q[$];   // {address, word} in write order
  logic [63:0] wr_log[$];  // every write observed on the bus
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit         m_active;
  bit         m_done;
  bit         m_ovf;
  int         m_addr;
  logic [7:0] m_bytes[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_start();
    if (!m_active) begin
      m_active = 1;
      m_addr   = 0;
      m_done   = 0;
      m_ovf    = 0;
      m_bytes.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (m_active) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
        w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        m_bytes.delete();
        exp_q.push_back({32'(m_addr), w});
        if (w == HALT) begin
          m_active = 0;
          m_done   = 1;
        end else if (m_addr == TAM - 1) begin
          m_active = 0;
          m_ovf    = 1;
        end else begin
          m_addr++;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_ovf    = 0;
    m_addr   = 0;
    m_bytes.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks (all drives at posedge + 1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = $urandom_range(0, 255);
    model_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, max_gap));
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    @(posedge clk);
    #1;
    start_load = 1'b0;
    model_start();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 3000), 64'd1);
    check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_load_done"}, 64'(load_done), 64'(m_done));
    check({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
  endtask

  // ---------------- per-cycle write monitor ----------------
  logic          prev_wr;
  logic [NB-1:0] prev_instr;
  logic [NB-1:0] prev_addr;

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      prev_wr = 1'b0;
    end else begin
      if (wr) begin
        wr_log.push_back({addr, instr});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data %h, expected no write", addr, instr);
        end else begin
          e = exp_q.pop_front();
          check("write_addr_data", {addr, instr}, e);
        end
        check("strobe_single_cycle", 64'(prev_wr), 64'd0);
        check("setup_stable", {prev_addr, prev_instr}, {addr, instr});
        check("busy_in_strobe", 64'(busy), 64'd1);
        check("addr_in_range", 64'(addr < TAM), 64'd1);
      end
      prev_wr    = wr;
      prev_instr = instr;
      prev_addr  = addr;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    int nwords;
    rst        = 1'b1;
    start_load = 1'b0;
    rx_data    = 8'h00;
    rx_done    = 1'b0;
    model_reset();
    #1;
    check("reset_outputs", {wr, busy, load_done, overflow, instr, addr},
          {4'b0000, 32'h0, 32'h0});
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // rx_done in IDLE is ignored; nothing must be written
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 1);
    idle(3);
    check("idle_ignores_rx_busy", 64'(busy), 64'd0);

    // Directed program: 13 00 20 00, then the halt marker
    wr_log.delete();
    pulse_start();
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h20, 0);
    send_byte(8'h00, 0);
    check("instr_after_4th_byte", 64'(instr), 64'h0020_0013);
    check("no_strobe_at_e0", 64'(wr), 64'd0);
    idle(1);
    check("strobe_high_e1", 64'(wr), 64'd1);
    idle(1);
    check("strobe_low_e2", 64'(wr), 64'd0);
    send_word(HALT, 0);
    wait_done("directed");
    check("directed_wr0", wr_log[0], {32'd0, 32'h0020_0013});
    check("directed_wr1", wr_log[1], {32'd1, 32'hFFFF_FFFF});
    check("directed_done_lit", 64'(load_done), 64'd1);

    // Back-to-back bytes for 3 words, start_load ignored mid-word
    wr_log.delete();
    pulse_start();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    pulse_start();
    check("busy_after_ignored_start", 64'(busy), 64'd1);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_word(32'hCAFE_0001, 0);
    send_word(32'h1234_5678, 0);
    send_word(HALT, 0);
    wait_done("b2b");
    check("b2b_wr0", wr_log[0], {32'd0, 32'h4433_2211});
    check("b2b_wr2", wr_log[2], {32'd2, 32'h1234_5678});
    check("b2b_count", 64'(wr_log.size()), 64'd4);

    // Randomized loads, with stray bytes before start and after the halt word
    for (int l = 0; l < 8; l++) begin
      for (int j = 0; j < $urandom_range(0, 2); j++) send_byte($urandom_range(0, 255), 0);
      pulse_start();
      nwords = $urandom_range(1, 12);
      for (int k = 0; k < nwords; k++) begin
        w = $urandom;
        if (k == nwords - 1) w = HALT;
        else if (w == HALT) w = 32'h0;
        send_word(w, 2);
      end
      for (int j = 0; j < $urandom_range(0, 3); j++) send_byte($urandom_range(0, 255), 0);
      wait_done("rand_load");
    end

    // Overflow: TAM non-halt words, then one more that must not be written
    wr_log.delete();
    pulse_start();
    for (int k = 0; k < TAM; k++) begin
      w = $urandom;
      if (w == HALT) w = 32'h1;
      send_word(w, 1);
    end
    send_word(32'h0BAD_0BAD, 0);
    idle(5);
    wait_done("overflow");
    check("overflow_write_count", 64'(wr_log.size()), 64'(TAM));
    check("overflow_last_addr", 64'(wr_log[TAM-1][63:32]), 64'(TAM - 1));
    check("overflow_flag_lit", 64'(overflow), 64'd1);

    // Reset while the strobe is high and the next word has started
    wr_log.delete();
    pulse_start();
    send_word(32'h0102_0304, 0);
    send_byte(8'h77, 0);
    check("pre_reset_in_strobe", 64'(wr), 64'd1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_reset_outputs", {wr, busy, load_done, overflow, instr, addr},
          {4'b0000, 32'h0, 32'h0});
    idle(2);
    rst = 1'b0;
    idle(2);
    check("after_reset_idle_busy", 64'(busy), 64'd0);
    send_word(32'h0000_0099, 0);
    pulse_start();
    send_word(32'hDEAD_BEEF, 1);
    send_word(HALT, 1);
    wait_done("reload");
    check("reload_wr0", wr_log[0], {32'd0, 32'hDEAD_BEEF});
    check("reload_count", 64'(wr_log.size()), 64'd2);

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
